// File: rtl/cp0_pkg.sv
// CP0 exception-control constants: register addresses, ExcCodes, field positions, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cp0_pkg;

    // CP0 register numbers visible through mtc0 / c0_rdata
    localparam logic [4:0] C0_STATUS = 5'd12;
    localparam logic [4:0] C0_CAUSE  = 5'd13;
    localparam logic [4:0] C0_EPC    = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // status fields
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IM_LSB     = 8;
    localparam int IM_MSB     = 15;

    // cause fields
    localparam int CAUSE_BD     = 31;
    localparam int IP_LSB       = 8;
    localparam int IP_MSB       = 15;
    localparam int IP_SW_LSB    = 8;   // IP[1:0], software interrupts
    localparam int IP_HW_LSB    = 10;  // IP[7:2], external lines
    localparam int EXC_CODE_LSB = 2;

    // exception FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENTER   = 2'd1;
    localparam logic [1:0] ST_HANDLER = 2'd2;
    localparam logic [1:0] ST_LEAVE   = 2'd3;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser for the asynchronous external interrupt lines.
// Latency: 2 clk cycles from input change to sync_out.
// Backpressure: none; samples every cycle.
//   Ports: clk, rst_n (async active-low), async_in[WIDTH-1:0] -> sync_out[WIDTH-1:0]
module int_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/exception_ctrl.sv
// CP0 exception controller: records EPC/cause/EXL, flushes and redirects the pipeline on entry and ERET.
// Latency: exc_req/pending interrupt at edge N -> flush to HANDLER_VEC in cycle N+1; eret at edge N -> redirect to EPC in N+1.
// Backpressure: none; requests outside IDLE are ignored (no nesting), eret outside HANDLER is ignored.
//   Ports: clk, rst_n; exc_req/exc_code/exc_pc/exc_bd, int_pc, ext_int, eret; mtc0_we/c0_addr/c0_wdata -> c0_rdata;
//          cause/EPC/status live registers; flush, redirect_valid, redirect_pc.
module exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] int_pc,
    input  logic [5:0]  ext_int,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  c0_addr,
    input  logic [31:0] c0_wdata,
    output logic [31:0] c0_rdata,
    output logic [31:0] cause,
    output logic [31:0] EPC,
    output logic [31:0] status,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    logic [1:0]  state_q, state_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw;
    logic        int_pending;
    logic        take_exc;

    int_sync #(.WIDTH(6)) u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ext_int),
        .sync_out (ip_hw)
    );

    // IP[7:2] is the synchroniser output itself, so no extra flop sits in the interrupt path.
    assign cause = {bd_q, 15'd0, ip_hw, ip_sw_q, 1'b0, code_q, 2'b00};
    assign EPC    = epc_q;
    assign status = status_q;

    assign int_pending = ((cause[IP_MSB:IP_LSB] & status_q[IM_MSB:IM_LSB]) != 8'd0)
                         && status_q[STATUS_IE] && !status_q[STATUS_EXL];

    // Synchronous exceptions take priority over interrupts in the same cycle.
    assign take_exc = (state_q == ST_IDLE) && (exc_req || int_pending);

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        epc_d    = epc_q;
        bd_d     = bd_q;
        code_d   = code_q;
        ip_sw_d  = ip_sw_q;

        // Software writes first; exception/eret updates below override overlapping fields.
        if (mtc0_we) begin
            case (c0_addr)
                C0_STATUS: status_d = c0_wdata;
                C0_CAUSE:  ip_sw_d  = c0_wdata[IP_SW_LSB+1:IP_SW_LSB];
                C0_EPC:    epc_d    = c0_wdata;
                default:   ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (take_exc) begin
                    if (exc_req) begin
                        epc_d  = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                        bd_d   = exc_bd;
                        code_d = exc_code;
                    end else begin
                        epc_d  = int_pc;
                        bd_d   = 1'b0;
                        code_d = EXC_INT;
                    end
                    status_d[STATUS_EXL] = 1'b1;
                    state_d = ST_ENTER;
                end
            end
            ST_ENTER:   state_d = ST_HANDLER;
            ST_HANDLER: begin
                if (eret) begin
                    status_d[STATUS_EXL] = 1'b0;
                    state_d = ST_LEAVE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            status_q <= '0;
            epc_q    <= '0;
            bd_q     <= 1'b0;
            code_q   <= '0;
            ip_sw_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            epc_q    <= epc_d;
            bd_q     <= bd_d;
            code_q   <= code_d;
            ip_sw_q  <= ip_sw_d;
        end
    end

    // Decoded straight from the state flop so reset kills the pulse immediately.
    always_comb begin
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (state_q == ST_ENTER) begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = HANDLER_VEC;
        end else if (state_q == ST_LEAVE) begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = epc_q;
        end
    end

    always_comb begin
        case (c0_addr)
            C0_STATUS: c0_rdata = status_q;
            C0_CAUSE:  c0_rdata = cause;
            C0_EPC:    c0_rdata = epc_q;
            default:   c0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

    localparam logic [31:0] HVEC = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic        exc_bd = 1'b0;
    logic [31:0] int_pc = '0;
    logic [5:0]  ext_int = '0;
    logic        eret = 1'b0;
    logic        mtc0_we = 1'b0;
    logic [4:0]  c0_addr = '0;
    logic [31:0] c0_wdata = '0;
    logic [31:0] c0_rdata, cause, epc, status, redirect_pc;
    logic        flush, redirect_valid;

    always #5 clk = ~clk;

    exception_ctrl #(.HANDLER_VEC(HVEC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_req        (exc_req),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_bd         (exc_bd),
        .int_pc         (int_pc),
        .ext_int        (ext_int),
        .eret           (eret),
        .mtc0_we        (mtc0_we),
        .c0_addr        (c0_addr),
        .c0_wdata       (c0_wdata),
        .c0_rdata       (c0_rdata),
        .cause          (cause),
        .EPC            (epc),
        .status         (status),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic        flush;
        logic [31:0] rpc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] status;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] redir_q[$];
    exp_t        mon_e;
    logic [31:0] mon_r;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural registers plus where the controller is in the
    // entry/handler/return sequence.
    typedef enum int {P_RUN, P_ENTRY_FLUSH, P_IN_HANDLER, P_RETURN_FLUSH} phase_t;
    phase_t      m_phase;
    logic [31:0] m_status, m_epc;
    logic        m_bd;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_ext_d1, m_ext_d2;   // ext_int as seen one and two edges ago

    function automatic logic [31:0] m_cause();
        return {m_bd, 15'd0, m_ext_d2, m_ipsw, 1'b0, m_code, 2'b00};
    endfunction

    task automatic model_reset();
        m_phase = P_RUN; m_status = 0; m_epc = 0; m_bd = 0; m_code = 0; m_ipsw = 0;
        m_ext_d1 = 0; m_ext_d2 = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [31:0] c;
        logic        pend;
        exp_t        e;
        c = m_cause();
        pend = ((c[15:8] & m_status[15:8]) != 0) && m_status[0] && !m_status[1];
        if (mtc0_we) begin
            if (c0_addr == 5'd12)      m_status = c0_wdata;
            else if (c0_addr == 5'd13) m_ipsw = c0_wdata[9:8];
            else if (c0_addr == 5'd14) m_epc = c0_wdata;
        end
        case (m_phase)
            P_RUN: begin
                if (exc_req) begin
                    m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                    m_bd = exc_bd; m_code = exc_code; m_status[1] = 1'b1;
                    m_phase = P_ENTRY_FLUSH;
                end else if (pend) begin
                    m_epc = int_pc; m_bd = 1'b0; m_code = 5'd0; m_status[1] = 1'b1;
                    m_phase = P_ENTRY_FLUSH;
                end
            end
            P_ENTRY_FLUSH: m_phase = P_IN_HANDLER;
            P_IN_HANDLER: if (eret) begin m_status[1] = 1'b0; m_phase = P_RETURN_FLUSH; end
            default: m_phase = P_RUN;
        endcase
        m_ext_d2 = m_ext_d1;
        m_ext_d1 = ext_int;

        e.flush  = (m_phase == P_ENTRY_FLUSH) || (m_phase == P_RETURN_FLUSH);
        e.rpc    = (m_phase == P_ENTRY_FLUSH) ? HVEC : (m_phase == P_RETURN_FLUSH) ? m_epc : 32'd0;
        e.epc    = m_epc;
        e.cause  = m_cause();
        e.status = m_status;
        e.rdata  = (c0_addr == 5'd12) ? m_status : (c0_addr == 5'd13) ? e.cause :
                   (c0_addr == 5'd14) ? m_epc : 32'd0;
        exp_q.push_back(e);
        if (e.flush) redir_q.push_back(e.rpc);
    endtask

    // Monitor: samples on the falling edge, pops whatever the model predicted.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("flush", {31'd0, flush}, {31'd0, mon_e.flush});
            check("redirect_valid", {31'd0, redirect_valid}, {31'd0, mon_e.flush});
            check("redirect_pc_cycle", redirect_pc, mon_e.rpc);
            check("EPC", epc, mon_e.epc);
            check("cause", cause, mon_e.cause);
            check("status", status, mon_e.status);
            check("c0_rdata", c0_rdata, mon_e.rdata);
        end
        if (flush === 1'b1) begin
            if (redir_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_flush: got flush=1 redirect_pc=%h, expected no flush", redirect_pc);
            end else begin
                mon_r = redir_q.pop_front();
                check("redirect_target", redirect_pc, mon_r);
            end
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
        exc_req = 1'b0; eret = 1'b0; mtc0_we = 1'b0; exc_bd = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd);
        exc_req = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
        tick();
    endtask

    task automatic wr_c0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; c0_addr = a; c0_wdata = d;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flush"}, {31'd0, flush}, 32'd0);
        check({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        check({tag, "_cause"}, cause, 32'd0);
        check({tag, "_EPC"}, epc, 32'd0);
        check({tag, "_status"}, status, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Plain synchronous exception, then return.
        raise(5'd12, 32'h0000_0040, 1'b0);
        check("entry_flush", {31'd0, flush}, 32'd1);
        check("entry_target", redirect_pc, 32'h0000_0180);
        check("entry_epc", epc, 32'h40);
        check("entry_code", {27'd0, cause[6:2]}, 32'd12);
        check("entry_exl", {31'd0, status[1]}, 32'd1);
        tick();
        eret = 1'b1; tick();
        check("eret_target", redirect_pc, 32'h40);
        check("eret_exl", {31'd0, status[1]}, 32'd0);
        tick();

        // Branch-delay exception, ignored nested request, return.
        raise(5'd10, 32'h0000_0100, 1'b1);
        check("bd_epc", epc, 32'h0000_00FC);
        check("bd_bit", {31'd0, cause[31]}, 32'd1);
        tick();
        raise(5'd4, 32'h0000_0999, 1'b0);
        check("nested_epc", epc, 32'h0000_00FC);
        eret = 1'b1; tick();
        check("bd_eret_target", redirect_pc, 32'h0000_00FC);
        tick();

        // External interrupt with IE=1.
        wr_c0(5'd12, 32'h0000_0401);
        ext_int = 6'h01; int_pc = 32'h0000_0200;
        ticks(2);
        check("int_not_yet", {31'd0, flush}, 32'd0);
        tick();
        check("int_flush", {31'd0, flush}, 32'd1);
        check("int_epc", epc, 32'h200);
        check("int_code", {27'd0, cause[6:2]}, 32'd0);
        ext_int = 6'h00;
        ticks(3);
        eret = 1'b1; tick();
        ticks(2);

        // Same interrupt with IE=0: no flush expected at any point.
        wr_c0(5'd12, 32'h0000_0400);
        ext_int = 6'h01;
        ticks(5);
        check("ie0_no_flush", {31'd0, flush}, 32'd0);
        ext_int = 6'h00;
        ticks(3);

        // Exception + pending interrupt + mtc0 EPC in one cycle.
        wr_c0(5'd12, 32'h0000_0401);
        ext_int = 6'h01; int_pc = 32'h0000_0777;
        ticks(2);
        exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h0000_0300;
        mtc0_we = 1'b1; c0_addr = 5'd14; c0_wdata = 32'h5555_5555;
        tick();
        check("prio_epc", epc, 32'h0000_0300);
        check("prio_code", {27'd0, cause[6:2]}, 32'd10);
        ext_int = 6'h00;
        ticks(3);
        eret = 1'b1; tick();
        ticks(2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            exc_req  = ($urandom_range(0, 5) == 0);
            exc_code = 5'($urandom);
            exc_pc   = {$urandom, 2'b00} >> 2 << 2;
            exc_bd   = 1'($urandom);
            int_pc   = $urandom & 32'hFFFF_FFFC;
            eret     = ($urandom_range(0, 3) == 0);
            mtc0_we  = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: c0_addr = 5'd12;
                1: c0_addr = 5'd13;
                2: c0_addr = 5'd14;
                default: c0_addr = 5'($urandom);
            endcase
            c0_wdata = $urandom;
            if ($urandom_range(0, 19) == 0) ext_int = 6'($urandom);
            tick();
        end

        // Return to a quiet IDLE, then reset in the middle of entry.
        ext_int = 6'h00;
        wr_c0(5'd12, 32'h0);
        for (int i = 0; i < 4; i++) begin
            eret = 1'b1; tick();
        end
        ext_int = 6'h3F;
        ticks(2);
        raise(5'd8, 32'h0000_0500, 1'b0);
        check("pre_reset_flush", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("reset_in_entry");
        @(negedge clk); #1;
        check_all_zero("reset_hold");
        ext_int = 6'h00;
        rst_n = 1'b1;
        ticks(4);

        check("leftover_redirects", redir_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
